padding_scan_ctrl: RTL and testbench
====================================

Name: padding_scan_ctrl

Overview:
- Sequencer for the `padding` address unit.
- On a start pulse it latches a layer configuration and walks every coordinate of the padded feature map in raster order (y outer, x inner). It drives `padding` with each (x, y) and buffers each result in a one-entry output register.
- The buffered (realAddr, realAddrEn, x, y) beats stream to the downstream fetch/fill stage over a valid/ready handshake. It can optionally suppress padding-location beats.

Parameters:
- ADDR_W, 64, width of baseAddr/realAddr.
- COORD_W, 11, width of x/y/fmX/fmY.
- PAD_W, 4, width of each padding amount.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- cfgBaseAddr  in  ADDR_W  feature-map base address.
- cfgFmX / cfgFmY  in  COORD_W each  feature-map width / height.
- cfgPadUp / cfgPadDown / cfgPadLeft / cfgPadRight  in  PAD_W each  padding amounts.
- cfgSkipPad  in  1  1 = drop beats with realAddrEn==1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of scan.
- cfgErr  out  1  one-cycle pulse: start rejected, padded extent too large.
- protoErr  out  1  sticky; set when `padding` returns realAddrEn==0. Cleared by the next accepted start or by rst.
- padX / padY  out  COORD_W each  coordinates to `padding`.
- padBaseAddr  out  ADDR_W  latched base address.
- padFmX / padFmY  out  COORD_W each  latched dimensions.
- padUp / padDown / padLeft / padRight  out  PAD_W each  latched padding amounts.
- padInReady  out  1  request to `padding`.
- padRealAddr  in  ADDR_W  result from `padding`.
- padRealAddrEn  in  2  0 false value; 1 padding location; 2 feature-map location.
- padOutReady  in  1  result valid.
- outValid  out  1  beat valid.
- outReady  in  1  downstream accepts.
- outAddr  out  ADDR_W  beat realAddr.
- outAddrEn  out  2  beat realAddrEn.
- outX / outY  out  COORD_W each  beat padded coordinates.
- beatCnt  out  2*COORD_W  beats emitted this scan; held after done until the next start.

Behaviour:
- Reset values:
  - state IDLE.
  - busy, done, cfgErr, protoErr, padInReady, outValid = 0.
  - padX, padY, outX, outY, outAddr, outAddrEn, beatCnt = 0.
  - Latched config registers = 0.
- rst mid-scan: same cycle returns to IDLE. Any held beat is discarded; no done pulse.
- Extents: W = fmX + padLeft + padRight, H = fmY + padUp + padDown, computed at COORD_W+2 bits.
- Start in IDLE:
  - If W > 2^COORD_W or H > 2^COORD_W: pulse cfgErr, stay IDLE, latch nothing.
  - Else if W==0 or H==0: pulse done on the next cycle, no beats, busy stays 0.
  - Else: latch config, clear protoErr and beatCnt, set x = y = 0, go to BUSY.
- start while busy: ignored.
- States:
  - IDLE: as above.
  - BUSY: padInReady = 1; padX/padY = current x/y.
    - capture = padOutReady & (!outValid | outReady).
    - On capture with x==W-1, y==H-1: go to DRAIN.
  - DRAIN: padInReady = 0; wait until outValid==0, then pulse done and go to IDLE. If outValid is already 0, done pulses the next cycle.
- Per-cycle rules in BUSY:
  - padX/padY and latched config are stable while capture is low.
  - On capture, x advances: x+1, or wrap to 0 with y+1 when x==W-1.
  - On capture, the result is loaded into the output register unless dropped.
- Drop rules:
  - en==1 with cfgSkipPad: coordinate advances, output register not loaded.
  - en==0: set protoErr, coordinate advances, output register not loaded.
- Output register:
  - outValid rises the cycle after a loading capture.
  - If outReady and a new load occur in the same cycle, the register is replaced: back-to-back beats, throughput 1 beat/cycle.
  - outValid && !outReady: contents hold stable and padOutReady is ignored.
  - beatCnt increments on each outValid & outReady.
- `padding` contract for checking:
  - Padded (x, y) is inside the feature map iff padLeft ≤ x < padLeft+fmX and padUp ≤ y < padUp+fmY.
  - Inside: en=2, addr = base + (y−padUp)*fmX + (x−padLeft).
  - Outside: en=1.

Decomposition:
- Shared package `padding_pkg`:
  - realAddrEn encoding constants EN_FALSE=0, EN_PAD=1, EN_FM=2.
  - State enum IDLE/BUSY/DRAIN.
  - Default width constants.
- Natural sub-module: `raster_counter`. It holds W and H, provides x/y with advance, wrap and a last flag, and is reused by later window controllers.

Test Plan:
- Base 4, fm 5x5, pad 2 on all sides, outReady=1 → 81 beats. Beat (3,2) gives addr 5, en 2. Beat (2,4) gives addr 14, en 2. Beat (4,5) gives addr 21, en 2. Beat (0,0) gives en 1. done one cycle after the last accept; beatCnt=81.
- Same config with cfgSkipPad=1 → exactly 25 beats, addresses 4..28 in order.
- outReady toggles 1-0-0-1 pattern → no beat lost or duplicated; outAddr is stable while stalled; total beats still 81.
- fmX = fmY = 0 with zero padding → done the cycle after start, busy 0. fmX=2047 with padLeft=padRight=15 → cfgErr pulse, state stays IDLE.
- padRealAddrEn forced to 0 for one capture → protoErr set and held, that beat dropped (80 beats). Next start clears protoErr.
- rst asserted at beat 40 → next cycle outValid=0, busy=0, no done. A new start then restarts at (0,0).

Source files
------------

// File: rtl/padding_pkg.sv
// Shared definitions for the padding address unit and its scan sequencers.
package padding_pkg;

  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned COORD_W_DEF = 11;
  localparam int unsigned PAD_W_DEF   = 4;

  // realAddrEn encoding returned by the padding unit
  localparam logic [1:0] EN_FALSE = 2'd0;
  localparam logic [1:0] EN_PAD   = 2'd1;
  localparam logic [1:0] EN_FM    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } scanState_t;

endpackage

// File: rtl/padding_scan_ctrl_raster_counter.sv
// Raster-order (y outer, x inner) coordinate walker over a W x H extent.
module raster_counter #(
  parameter int unsigned COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W:0]   extW,
  input  logic [COORD_W:0]   extH,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               atLast_c
);

  localparam int unsigned EW = COORD_W + 1;

  logic [COORD_W:0] wReg;
  logic [COORD_W:0] hReg;
  logic             xLast;
  logic             yLast;

  // extents reach 2^COORD_W, so compare one bit wider than the coordinates
  assign xLast    = (EW'(x) + EW'(1)) == wReg;
  assign yLast    = (EW'(y) + EW'(1)) == hReg;
  assign atLast_c = xLast & yLast;

  always_ff @(posedge clk) begin
    if (rst) begin
      wReg <= '0;
      hReg <= '0;
      x    <= '0;
      y    <= '0;
    end else if (load) begin
      wReg <= extW;
      hReg <= extH;
      x    <= '0;
      y    <= '0;
    end else if (advance) begin
      if (xLast) begin
        x <= '0;
        y <= yLast ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/padding_scan_ctrl.sv
// Walks the padded feature map, drives the padding unit and streams its
// results downstream through a one-entry valid/ready output register.
module padding_scan_ctrl
  import padding_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned PAD_W   = PAD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cfgBaseAddr,
  input  logic [COORD_W-1:0]   cfgFmX,
  input  logic [COORD_W-1:0]   cfgFmY,
  input  logic [PAD_W-1:0]     cfgPadUp,
  input  logic [PAD_W-1:0]     cfgPadDown,
  input  logic [PAD_W-1:0]     cfgPadLeft,
  input  logic [PAD_W-1:0]     cfgPadRight,
  input  logic                 cfgSkipPad,
  output logic                 busy,
  output logic                 done,
  output logic                 cfgErr,
  output logic                 protoErr,
  output logic [COORD_W-1:0]   padX,
  output logic [COORD_W-1:0]   padY,
  output logic [ADDR_W-1:0]    padBaseAddr,
  output logic [COORD_W-1:0]   padFmX,
  output logic [COORD_W-1:0]   padFmY,
  output logic [PAD_W-1:0]     padUp,
  output logic [PAD_W-1:0]     padDown,
  output logic [PAD_W-1:0]     padLeft,
  output logic [PAD_W-1:0]     padRight,
  output logic                 padInReady,
  input  logic [ADDR_W-1:0]    padRealAddr,
  input  logic [1:0]           padRealAddrEn,
  input  logic                 padOutReady,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [ADDR_W-1:0]    outAddr,
  output logic [1:0]           outAddrEn,
  output logic [COORD_W-1:0]   outX,
  output logic [COORD_W-1:0]   outY,
  output logic [2*COORD_W-1:0] beatCnt
);

  localparam int unsigned EXT_W = COORD_W + 2;
  localparam int unsigned CNT_W = 2 * COORD_W;
  localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(2 ** COORD_W);

  scanState_t state, nextState;

  logic [EXT_W-1:0]   extW;
  logic [EXT_W-1:0]   extH;
  logic               tooBig;
  logic               zeroExt;
  logic               startScan;
  logic               capture;
  logic               loadBeat;
  logic               protoHit;
  logic               doneNext;
  logic               cfgErrNext;
  logic               atLast;
  logic               skipPad;
  logic [COORD_W-1:0] curX;
  logic [COORD_W-1:0] curY;

  assign extW    = EXT_W'(cfgFmX) + EXT_W'(cfgPadLeft) + EXT_W'(cfgPadRight);
  assign extH    = EXT_W'(cfgFmY) + EXT_W'(cfgPadUp) + EXT_W'(cfgPadDown);
  assign tooBig  = (extW > EXT_MAX) || (extH > EXT_MAX);
  assign zeroExt = (extW == '0) || (extH == '0);

  raster_counter #(.COORD_W(COORD_W)) uCounter (
    .clk      (clk),
    .rst      (rst),
    .load     (startScan),
    .extW     ((COORD_W+1)'(extW)),
    .extH     ((COORD_W+1)'(extH)),
    .advance  (capture),
    .x        (curX),
    .y        (curY),
    .atLast_c (atLast)
  );

  assign padX = curX;
  assign padY = curY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      padInReady <= 1'b0;
      done       <= 1'b0;
      cfgErr     <= 1'b0;
    end else begin
      state      <= nextState;
      busy       <= nextState != IDLE;
      padInReady <= nextState == BUSY;
      done       <= doneNext;
      cfgErr     <= cfgErrNext;
    end
  end

  // A full output register blocks capture unless it drains this same cycle
  always_comb begin
    nextState  = state;
    doneNext   = 1'b0;
    cfgErrNext = 1'b0;
    startScan  = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (tooBig) begin
            cfgErrNext = 1'b1;
          end else if (zeroExt) begin
            doneNext = 1'b1;
          end else begin
            startScan = 1'b1;
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        capture = padOutReady & (~outValid | outReady);
        if (capture && atLast) nextState = DRAIN;
      end
      DRAIN: begin
        if (!outValid || outReady) begin
          doneNext  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    loadBeat = capture & ((padRealAddrEn == EN_FM) | ((padRealAddrEn == EN_PAD) & ~skipPad));
    protoHit = capture & (padRealAddrEn == EN_FALSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      padBaseAddr <= '0;
      padFmX      <= '0;
      padFmY      <= '0;
      padUp       <= '0;
      padDown     <= '0;
      padLeft     <= '0;
      padRight    <= '0;
      skipPad     <= 1'b0;
      protoErr    <= 1'b0;
      beatCnt     <= '0;
      outValid    <= 1'b0;
      outAddr     <= '0;
      outAddrEn   <= '0;
      outX        <= '0;
      outY        <= '0;
    end else begin
      if (startScan) begin
        padBaseAddr <= cfgBaseAddr;
        padFmX      <= cfgFmX;
        padFmY      <= cfgFmY;
        padUp       <= cfgPadUp;
        padDown     <= cfgPadDown;
        padLeft     <= cfgPadLeft;
        padRight    <= cfgPadRight;
        skipPad     <= cfgSkipPad;
        protoErr    <= 1'b0;
        beatCnt     <= '0;
      end else begin
        if (protoHit) protoErr <= 1'b1;
        if (outValid && outReady) beatCnt <= beatCnt + CNT_W'(1);
      end
      if (loadBeat) begin
        outValid  <= 1'b1;
        outAddr   <= padRealAddr;
        outAddrEn <= padRealAddrEn;
        outX      <= curX;
        outY      <= curY;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_padding_scan_ctrl.sv
// Self-checking bench for padding_scan_ctrl with a behavioural padding-unit model.
module tb_padding_scan_ctrl;

  localparam int ADDR_W  = 64;
  localparam int COORD_W = 11;
  localparam int PAD_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, cfgSkipPad;
  logic [ADDR_W-1:0]    cfgBaseAddr;
  logic [COORD_W-1:0]   cfgFmX, cfgFmY;
  logic [PAD_W-1:0]     cfgPadUp, cfgPadDown, cfgPadLeft, cfgPadRight;
  logic                 busy, done, cfgErr, protoErr;
  logic [COORD_W-1:0]   padX, padY, padFmX, padFmY;
  logic [ADDR_W-1:0]    padBaseAddr;
  logic [PAD_W-1:0]     padUp, padDown, padLeft, padRight;
  logic                 padInReady, padOutReady;
  logic [ADDR_W-1:0]    padRealAddr;
  logic [1:0]           padRealAddrEn;
  logic                 outValid, outReady;
  logic [ADDR_W-1:0]    outAddr;
  logic [1:0]           outAddrEn;
  logic [COORD_W-1:0]   outX, outY;
  logic [2*COORD_W-1:0] beatCnt;

  padding_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfgBaseAddr(cfgBaseAddr), .cfgFmX(cfgFmX), .cfgFmY(cfgFmY),
    .cfgPadUp(cfgPadUp), .cfgPadDown(cfgPadDown), .cfgPadLeft(cfgPadLeft),
    .cfgPadRight(cfgPadRight), .cfgSkipPad(cfgSkipPad),
    .busy(busy), .done(done), .cfgErr(cfgErr), .protoErr(protoErr),
    .padX(padX), .padY(padY), .padBaseAddr(padBaseAddr),
    .padFmX(padFmX), .padFmY(padFmY), .padUp(padUp), .padDown(padDown),
    .padLeft(padLeft), .padRight(padRight), .padInReady(padInReady),
    .padRealAddr(padRealAddr), .padRealAddrEn(padRealAddrEn),
    .padOutReady(padOutReady), .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .outAddrEn(outAddrEn), .outX(outX), .outY(outY),
    .beatCnt(beatCnt)
  );

  typedef struct {
    logic [63:0] a;
    logic [1:0]  en;
    int          x;
    int          y;
  } beat_t;

  int          assertCnt = 0;
  int          failCnt   = 0;
  logic [63:0] cBase;
  int          cFx, cFy, cPu, cPd, cPl, cPr;
  beat_t       expQ[$];
  logic [63:0] gotQ[$];
  logic [63:0] seenAddr[int];
  logic [1:0]  seenEn[int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // padding unit contract: inside the feature map -> linear address, else pad
  function automatic void padModel(input int x, input int y,
                                   output logic [63:0] a, output logic [1:0] en);
    if (x >= cPl && x < cPl + cFx && y >= cPu && y < cPu + cFy) begin
      en = 2'd2;
      a  = cBase + 64'((y - cPu) * cFx + (x - cPl));
    end else begin
      en = 2'd1;
      a  = 64'(x * 7 + y * 13 + 1000);
    end
  endfunction

  task automatic driveCfg(input bit skip);
    cfgBaseAddr = cBase;
    cfgFmX      = 11'(cFx);
    cfgFmY      = 11'(cFy);
    cfgPadUp    = 4'(cPu);
    cfgPadDown  = 4'(cPd);
    cfgPadLeft  = 4'(cPl);
    cfgPadRight = 4'(cPr);
    cfgSkipPad  = skip;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // readyMode: 0 always ready, 1 pattern 1-0-0-1, 2 random
  task automatic runScan(input bit skip, input int readyMode, input int forceIdx,
                         input int rstAt, input bit chkDoneTiming, input bit expProto,
                         input int budget);
    int W, H, capIdx, got, lastAcc, cyc, expCnt;
    bit doneSeen, stall;
    logic [63:0] a, hAddr;
    logic [1:0]  en;
    logic [21:0] hXY;
    beat_t sb;
    W = cFx + cPl + cPr;
    H = cFy + cPu + cPd;
    capIdx = 0; got = 0; lastAcc = -10; doneSeen = 0; stall = 0;
    hAddr = '0; hXY = '0;
    expQ.delete(); gotQ.delete(); seenAddr.delete(); seenEn.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        padModel(x, y, a, en);
        if (!(en == 2'd1 && skip) && (y * W + x) != forceIdx)
          expQ.push_back('{a: a, en: en, x: x, y: y});
      end
    expCnt = expQ.size();
    driveCfg(skip);
    pulseStart();
    check("busy_after_start", 64'(busy), 64'd1);
    check("beatcnt_cleared", 64'(beatCnt), 64'd0);
    check("proto_cleared", 64'(protoErr), 64'd0);
    check("latched_base", padBaseAddr, cBase);
    check("first_coord", {padY, padX}, 64'd0);
    for (cyc = 0; cyc < budget; cyc++) begin
      if (stall) begin
        check("stall_valid", 64'(outValid), 64'd1);
        check("stall_addr", outAddr, hAddr);
        check("stall_xy", {outY, outX}, 64'(hXY));
      end
      if (done) begin
        doneSeen = 1;
        break;
      end
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: outReady = 1'($urandom_range(0, 1));
      endcase
      padOutReady = ($urandom_range(0, 3) != 0);
      padModel(int'(padX), int'(padY), a, en);
      if (padInReady && padOutReady && (!outValid || outReady)) begin
        if (capIdx == forceIdx) en = 2'd0;
        capIdx++;
      end
      padRealAddr   = a;
      padRealAddrEn = en;
      if (outValid && outReady) begin
        check("beat_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          sb = expQ.pop_front();
          check("beat_addr", outAddr, sb.a);
          check("beat_en", 64'(outAddrEn), 64'(sb.en));
          check("beat_xy", {outY, outX}, 64'({11'(sb.y), 11'(sb.x)}));
        end
        seenAddr[int'(outY) * W + int'(outX)] = outAddr;
        seenEn[int'(outY) * W + int'(outX)]   = outAddrEn;
        gotQ.push_back(outAddr);
        got++;
        lastAcc = cyc;
        if (got == rstAt) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_outvalid", 64'(outValid), 64'd0);
          check("rst_busy", 64'(busy), 64'd0);
          check("rst_done", 64'(done), 64'd0);
          check("rst_padinready", 64'(padInReady), 64'd0);
          repeat (3) @(negedge clk);
          check("rst_no_done", 64'(done), 64'd0);
          return;
        end
      end
      stall = outValid && !outReady;
      hAddr = outAddr;
      hXY   = {outY, outX};
      @(negedge clk);
    end
    check("done_seen", 64'(doneSeen), 64'd1);
    check("beat_count", 64'(got), 64'(expCnt));
    check("beatcnt_out", 64'(beatCnt), 64'(expCnt));
    check("busy_at_done", 64'(busy), 64'd0);
    check("proto_err", 64'(protoErr), 64'(expProto));
    if (chkDoneTiming) check("done_latency", 64'(cyc), 64'(lastAcc + 1));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("beatcnt_held", 64'(beatCnt), 64'(expCnt));
  endtask

  task automatic baseCfg();
    cBase = 64'd4; cFx = 5; cFy = 5; cPu = 2; cPd = 2; cPl = 2; cPr = 2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; outReady = 1'b0; padOutReady = 1'b0;
    padRealAddr = '0; padRealAddrEn = '0;
    baseCfg();
    driveCfg(1'b0);
    repeat (2) @(negedge clk);
    check("rst_state", {busy, done, cfgErr, protoErr, padInReady, outValid}, 64'd0);
    check("rst_coords", {padY, padX, outY, outX}, 64'd0);
    check("rst_out", {outAddr[61:0], outAddrEn}, 64'd0);
    check("rst_beatcnt", 64'(beatCnt), 64'd0);
    check("rst_cfg", {padBaseAddr[19:0], padFmX, padFmY, padUp, padDown, padLeft, padRight}, 64'd0);
    rst = 1'b0;

    // full scan, always ready
    runScan(1'b0, 0, -1, -1, 1'b1, 1'b0, 2000);
    check("spot_3_2_addr", seenAddr[2 * 9 + 3], 64'd5);
    check("spot_3_2_en", 64'(seenEn[2 * 9 + 3]), 64'd2);
    check("spot_2_4_addr", seenAddr[4 * 9 + 2], 64'd14);
    check("spot_4_5_addr", seenAddr[5 * 9 + 4], 64'd21);
    check("spot_4_5_en", 64'(seenEn[5 * 9 + 4]), 64'd2);
    check("spot_0_0_en", 64'(seenEn[0]), 64'd1);
    check("latched_dims", {padFmX, padFmY, padUp, padDown, padLeft, padRight},
          {11'd5, 11'd5, 4'd2, 4'd2, 4'd2, 4'd2});

    // skip padding beats
    runScan(1'b1, 0, -1, -1, 1'b0, 1'b0, 2000);
    check("skip_count", 64'(gotQ.size()), 64'd25);
    for (int k = 0; k < gotQ.size(); k++) check("skip_addr_seq", gotQ[k], 64'(4 + k));

    // stalling downstream
    runScan(1'b0, 1, -1, -1, 1'b0, 1'b0, 3000);

    // zero extent
    cFx = 0; cFy = 0; cPu = 0; cPd = 0; cPl = 0; cPr = 0;
    driveCfg(1'b0);
    pulseStart();
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_no_latch", 64'(padFmX), 64'd5);

    // dropped false result
    baseCfg();
    runScan(1'b0, 0, 30, -1, 1'b1, 1'b1, 2000);
    check("proto_held", 64'(protoErr), 64'd1);

    // oversized extent
    cFx = 2047; cPl = 15; cPr = 15;
    driveCfg(1'b0);
    pulseStart();
    check("cfgerr_pulse", 64'(cfgErr), 64'd1);
    check("cfgerr_busy", 64'(busy), 64'd0);
    check("cfgerr_done", 64'(done), 64'd0);
    check("cfgerr_no_latch", 64'(padFmX), 64'd5);
    @(negedge clk);
    check("cfgerr_clear", {cfgErr, busy, padInReady}, 64'd0);
    check("cfgerr_proto_kept", 64'(protoErr), 64'd1);

    // reset mid-scan, then restart from origin
    baseCfg();
    runScan(1'b0, 0, -1, 40, 1'b0, 1'b0, 2000);
    runScan(1'b0, 2, -1, -1, 1'b1, 1'b0, 3000);

    // widest legal extent
    cBase = {$urandom, $urandom}; cFx = 2018; cFy = 1; cPl = 15; cPr = 15; cPu = 0; cPd = 0;
    runScan(1'b0, 0, -1, -1, 1'b1, 1'b0, 6000);

    // random configurations
    for (int r = 0; r < 4; r++) begin
      cBase = {$urandom, $urandom};
      cFx = $urandom_range(1, 6); cFy = $urandom_range(1, 6);
      cPu = $urandom_range(0, 3); cPd = $urandom_range(0, 3);
      cPl = $urandom_range(0, 3); cPr = $urandom_range(0, 3);
      runScan(1'($urandom_range(0, 1)), 2, -1, -1, 1'b0, 1'b0, 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
